// File: rtl/writeback_unit.sv
// Writeback stage: selects ALU/link results or formats returning load data,
// and drives a single-cycle register-file write strobe.
module writeback_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5,
  localparam int unsigned OFS_W = $clog2(XLEN / 8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_pc_plus4,
  input  logic [RA_W-1:0]  in_rd,
  input  logic             in_reg_write,
  input  logic [1:0]       in_result_sel,
  input  logic [2:0]       in_funct3,
  input  logic [OFS_W-1:0] in_addr_low,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             busy
);

  localparam int unsigned SH_W = OFS_W + 3;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              rf_we_q, rf_we_d;
  logic [RA_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic [RA_W-1:0]   rd_q, rd_d;
  logic              reg_write_q, reg_write_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [OFS_W-1:0]  addr_low_q, addr_low_d;

  logic              accept_c;
  logic [XLEN-1:0]   sel_data_c;
  logic [XLEN-1:0]   load_data_c;
  logic [31:0]       lane_word_c;
  logic [15:0]       lane_half_c;

  assign in_ready = rst_n && (state_q == IDLE) && !stall_i && !flush_i;
  assign accept_c = in_valid && in_ready;
  assign busy     = (state_q == WAIT_MEM);
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // Non-load result source; 2'b01 (MEM) never reaches this path.
  always_comb begin
    sel_data_c = in_alu_result;
    if (in_result_sel == 2'b10) begin
      sel_data_c = in_pc_plus4;
    end
  end

  // Halfword lanes are forced aligned by dropping the low offset bit.
  always_comb begin
    lane_word_c = 32'(mem_rdata >> SH_W'({addr_low_q, 3'b000}));
    lane_half_c = 16'(mem_rdata >> SH_W'({addr_low_q[OFS_W-1:1], 4'b0000}));
    case (funct3_q)
      3'b000:  load_data_c = XLEN'($signed(lane_word_c[7:0]));
      3'b100:  load_data_c = XLEN'(lane_word_c[7:0]);
      3'b001:  load_data_c = XLEN'($signed(lane_half_c));
      3'b101:  load_data_c = XLEN'(lane_half_c);
      3'b010:  load_data_c = XLEN'($signed(lane_word_c));
      3'b110:  load_data_c = (XLEN == 64) ? XLEN'(lane_word_c) : mem_rdata;
      default: load_data_c = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    funct3_d    = funct3_q;
    addr_low_d  = addr_low_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (in_result_sel == 2'b01) begin
            rd_d        = in_rd;
            reg_write_d = in_reg_write;
            funct3_d    = in_funct3;
            addr_low_d  = in_addr_low;
            state_d     = WAIT_MEM;
          end else if (in_reg_write && (in_rd != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = in_rd;
            rf_wdata_d = sel_data_c;
          end
        end
      end
      WAIT_MEM: begin
        // Flush wins over a same-cycle load return.
        if (flush_i) begin
          state_d = IDLE;
        end else if (mem_rvalid) begin
          state_d = IDLE;
          if (reg_write_q && (rd_q != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = rd_q;
            rf_wdata_d = load_data_c;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      funct3_q    <= '0;
      addr_low_q  <= '0;
    end else begin
      state_q     <= state_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      funct3_q    <= funct3_d;
      addr_low_q  <= addr_low_d;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed scenarios plus randomized
// traffic checked against a load-formatting reference model.
module tb_writeback_unit;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned RA_W  = 5;
  localparam int unsigned OFS_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall_i, flush_i, in_valid, in_ready;
  logic [XLEN-1:0]  in_alu_result, in_pc_plus4;
  logic [RA_W-1:0]  in_rd;
  logic             in_reg_write;
  logic [1:0]       in_result_sel;
  logic [2:0]       in_funct3;
  logic [OFS_W-1:0] in_addr_low;
  logic             mem_rvalid;
  logic [XLEN-1:0]  mem_rdata;
  logic             rf_we;
  logic [RA_W-1:0]  rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic             busy;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  writeback_unit #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_result_sel(in_result_sel),
    .in_funct3(in_funct3), .in_addr_low(in_addr_low),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference load formatting, computed with plain integer arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int al, input logic [31:0] w);
    int v;
    logic [31:0] lane;
    case (f3)
      3'd0, 3'd4: begin
        lane = w >> (8 * al);
        v = int'(lane & 32'hFF);
        if (f3 == 3'd0 && v >= 128) v -= 256;
        return 32'(v);
      end
      3'd1, 3'd5: begin
        lane = w >> (16 * (al / 2));
        v = int'(lane & 32'hFFFF);
        if (f3 == 3'd1 && v >= 32768) v -= 65536;
        return 32'(v);
      end
      3'd2:    return w >> (8 * al);
      default: return w;
    endcase
  endfunction

  // Present one instruction at a negedge; returns at the following negedge.
  task automatic send_op(input logic [1:0] sel, input logic [4:0] rd, input logic rw,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [2:0] f3, input logic [1:0] al, input logic rv_garbage);
    in_valid = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    in_result_sel = sel; in_rd = rd; in_reg_write = rw;
    in_alu_result = alu; in_pc_plus4 = pc4; in_funct3 = f3; in_addr_low = al;
    mem_rvalid = rv_garbage; mem_rdata = $urandom;
    #1 chk("in_ready_accept", in_ready, 1);
    if (sel != 2'b01 && rw && rd != 0)
      exp_q.push_back('{a: rd, d: (sel == 2'b10) ? pc4 : alu});
    @(negedge clk);
    in_valid = 1'b0; mem_rvalid = 1'b0;
    in_alu_result = $urandom; in_pc_plus4 = $urandom;
    in_rd = 5'($urandom); in_funct3 = 3'($urandom); in_addr_low = 2'($urandom);
  endtask

  // Hold the load outstanding for `waits` cycles, then return data.
  task automatic mem_resp(input int waits, input logic [31:0] data, input logic stall,
                          input logic flush, input logic [4:0] rd, input logic rw,
                          input logic [2:0] f3, input logic [1:0] al);
    repeat (waits) begin
      mem_rvalid = 1'b0; stall_i = stall;
      #1 chk("busy_wait", busy, 1);
      chk("ready_wait", in_ready, 0);
      @(negedge clk);
    end
    mem_rvalid = 1'b1; mem_rdata = data; stall_i = stall; flush_i = flush;
    if (!flush && rw && rd != 0) exp_q.push_back('{a: rd, d: ref_load(f3, int'(al), data)});
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = $urandom; stall_i = 1'b0; flush_i = 1'b0;
    #1 chk("busy_done", busy, 0);
    chk("ready_done", in_ready, 1);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got waddr=%0d wdata=0x%0h, required no write at %0t",
                 rf_waddr, rf_wdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("waddr", 64'(rf_waddr), 64'(mon_e.a));
        chk("wdata", 64'(rf_wdata), 64'(mon_e.d));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        rw;
    logic [2:0]  f3;
    logic [1:0]  al;

    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; in_valid = 1'b0;
    in_alu_result = '0; in_pc_plus4 = '0; in_rd = '0; in_reg_write = 1'b0;
    in_result_sel = '0; in_funct3 = '0; in_addr_low = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;

    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);

    // First acceptance on the first edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    send_op(2'b00, 5'd5, 1'b1, 32'h1234, 32'h0, 3'd0, 2'd0, 1'b0);
    #1 chk("alu_we", rf_we, 1);
    chk("alu_wdata", rf_wdata, 32'h0000_1234);
    @(negedge clk);
    #1 chk("alu_we_end", rf_we, 0);

    // JAL link, then an x0 destination that must not write.
    send_op(2'b10, 5'd1, 1'b1, 32'hDEAD_BEEF, 32'h100, 3'd0, 2'd0, 1'b0);
    send_op(2'b00, 5'd0, 1'b1, 32'hCAFE_F00D, 32'h0, 3'd0, 2'd0, 1'b0);
    #1 chk("x0_no_we", rf_we, 0);

    // Delayed LB; garbage rvalid in the acceptance cycle must be ignored.
    send_op(2'b01, 5'd7, 1'b1, 32'h0, 32'h0, 3'd0, 2'd2, 1'b1);
    mem_resp(3, 32'h0080_0000, 1'b0, 1'b0, 5'd7, 1'b1, 3'd0, 2'd2);
    chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);

    // LHU under stall, then LH.
    send_op(2'b01, 5'd9, 1'b1, 32'h0, 32'h0, 3'd5, 2'd2, 1'b0);
    mem_resp(2, 32'h8001_ABCD, 1'b1, 1'b0, 5'd9, 1'b1, 3'd5, 2'd2);
    chk("lhu_wdata", rf_wdata, 32'h0000_8001);
    send_op(2'b01, 5'd10, 1'b1, 32'h0, 32'h0, 3'd1, 2'd2, 1'b0);
    mem_resp(1, 32'h8001_ABCD, 1'b0, 1'b0, 5'd10, 1'b1, 3'd1, 2'd2);
    chk("lh_wdata", rf_wdata, 32'hFFFF_8001);

    // Flush coinciding with rvalid: no write, back to IDLE.
    send_op(2'b01, 5'd11, 1'b1, 32'h0, 32'h0, 3'd2, 2'd0, 1'b0);
    mem_resp(1, 32'h1357_9BDF, 1'b0, 1'b1, 5'd11, 1'b1, 3'd2, 2'd0);

    // Flush or stall in IDLE blocks acceptance.
    @(negedge clk);
    in_valid = 1'b1; in_result_sel = 2'b00; in_rd = 5'd3; in_reg_write = 1'b1;
    flush_i = 1'b1;
    #1 chk("ready_flush", in_ready, 0);
    @(negedge clk);
    flush_i = 1'b0; stall_i = 1'b1; in_result_sel = 2'b01;
    #1 chk("ready_stall", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0; stall_i = 1'b0;
    #1 chk("blocked_not_busy", busy, 0);

    // Reset during WAIT_MEM aborts the load.
    @(negedge clk);
    send_op(2'b01, 5'd12, 1'b1, 32'h0, 32'h0, 3'd2, 2'd0, 1'b0);
    #1 chk("rst_wait_busy", busy, 1);
    rst_n = 1'b0;
    #1 chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", in_ready, 0);
    chk("rst_mid_waddr", rf_waddr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1 chk("post_rst_we", rf_we, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_waddr", rf_waddr, 0);
    chk("post_rst_wdata", rf_wdata, 0);

    // Randomized traffic.
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b1; stall_i = 1'b1; in_result_sel = 2'b00;
        in_rd = 5'd4; in_reg_write = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; stall_i = 1'b0;
      end
      sel = 2'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 31));
      rw  = ($urandom_range(0, 3) != 0);
      f3  = 3'($urandom_range(0, 7));
      al  = 2'($urandom_range(0, 3));
      send_op(sel, rd, rw, $urandom, $urandom, f3, al, 1'($urandom_range(0, 1)));
      if (sel == 2'b01)
        mem_resp(int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), rd, rw, f3, al);
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
